fixed_vertex_packer: RTL
========================

// Module: fixed_vertex_packer
// PURPOSE
//  Downstream of the float_to_fixed converter. Consumes its AXI-stream of signed Q9.6 fixed values.
//  Groups three consecutive beats into one vertex, in the order x, y, z.
//  Rounds each coordinate to the nearest integer, clamps it to the screen/depth range, and emits
//  one registered vertex per triple on a valid/ready interface to the rasteriser.
// PARAMETERS
//  IN_W      16   input fixed-point width (two's complement)
//  FRAC_BITS 6    fractional bits in input
//  H_RES     320  horizontal resolution; x clamped to [0, H_RES-1]
//  V_RES     180  vertical resolution; y clamped to [0, V_RES-1]
//  X_W       9    output x width, $clog2(H_RES)
//  Y_W       8    output y width, $clog2(V_RES)
//  Z_W       8    output depth width; z clamped to [0, 2**Z_W-1]
// PORTS
//  clk       in  1     single clock, all logic rising-edge
//  rst_n     in  1     asynchronous, active-low reset
//  s_tdata   in  IN_W  fixed-point beat from converter
//  s_tvalid  in  1     beat valid
//  s_tready  out 1     beat accepted when s_tvalid && s_tready
//  m_x       out X_W   rounded/clamped x
//  m_y       out Y_W   rounded/clamped y
//  m_z       out Z_W   rounded/clamped depth
//  m_clip    out 1     1 if any coordinate of this vertex was clamped
//  m_valid   out 1     vertex valid
//  m_ready   in  1     consumer accepts when m_valid && m_ready
// BEHAVIOUR
//  - Reset (async assert, sync-released by the system): state=S_X, m_valid=0, m_x/m_y/m_z=0, m_clip=0,
//    staging registers=0. A reset mid-vertex discards the partial x/y; the next beat is x.
//  - FSM S_X -> S_Y -> S_Z -> S_X. Each state advances only on an accepted beat.
//    - S_X and S_Y latch the rounded/clamped value and its clip bit into staging.
//    - S_Z loads the output register: m_x/m_y from staging, m_z from the beat, m_clip = OR of three clip bits.
//  - s_tready = 1 in S_X and S_Y. In S_Z, s_tready = !m_valid || m_ready. The output register has
//    one entry; a stall back-pressures only the z beat.
//  - Latency: z beat accepted at edge N -> m_valid=1 after edge N. This sustains 1 vertex / 3 beats.
//  - m_valid is held with stable m_* until m_ready. Then it clears, unless a z beat is accepted in
//    the same cycle, in which case the register reloads and m_valid stays 1.
//  - Round: r = (sext(d, IN_W+1) + 2**(FRAC_BITS-1)) >>> FRAC_BITS. This is arithmetic, round-half-up,
//    and the extra bit prevents overflow at 0x7FFF.
//  - Clamp: r<0 -> 0, clip=1; r>MAX -> MAX, clip=1; else r, clip=0. MAX is H_RES-1, V_RES-1 or 2**Z_W-1.
//  - No timeout or resync input: beat order is trusted. The upstream always sends complete triples.
// STRUCTURE
//  - vertex_pkg:
//    - typedef struct packed {x, y, z, clip} vertex_t
//    - enum {S_X, S_Y, S_Z} pack_state_t
//    - localparam FRAC_BITS
//  - Sub-module fixed_round_clamp #(IN_W, FRAC_BITS, OUT_W, MAX): combinational round+clamp, outputs
//    value and clip. Three instances, or one shared instance muxed by state.
//  - Top: FSM, staging registers, output register + valid/ready logic.
// TESTING
//  1 Reset, then beats 0x1920 (100.5), 0x0C90 (50.25), 0x0100 (4.0), m_ready=1
//    -> one vertex: x=101, y=50, z=4, clip=0, m_valid high one cycle after z.
//  2 x=0x7D26 (500.6), y=0xFF40 (-3.0), z=0x7FFF
//    -> x=319, y=0, z=255, clip=1; no wrap from 0x7FFF.
//  3 m_ready=0, send two full triples back-to-back
//    -> first vertex held stable; s_tready drops on second z beat until m_ready=1, then second vertex
//       appears next cycle.
//  4 m_ready=1, continuous s_tvalid for 9 beats
//    -> 3 vertices, each m_valid pulse 3 cycles apart, values in order.
//  5 Send x, y, then assert rst_n=0 for 1 cycle, then a full triple
//    -> m_valid=0 during/after reset; the vertex built from the new triple only.
//  6 Ties: x=0x0020 (0.5) -> 1; x=0xFFE0 (-0.5) -> 0 with clip=0; x=0xFFDF -> 0 with clip=1.

Source files
------------

// File: rtl/vertex_pkg.sv
// Shared types and sizing for the fixed-point vertex packer.
// Coordinate widths follow the screen and depth ranges.
package vertex_pkg;

    localparam int IN_W      = 16;
    localparam int FRAC_BITS = 6;
    localparam int H_RES     = 320;
    localparam int V_RES     = 180;
    localparam int X_W       = 9;
    localparam int Y_W       = 8;
    localparam int Z_W       = 8;

    typedef struct packed {
        logic [X_W-1:0] x;
        logic [Y_W-1:0] y;
        logic [Z_W-1:0] z;
        logic           clip;
    } vertex_t;

    typedef enum logic [1:0] {
        S_X = 2'd0,
        S_Y = 2'd1,
        S_Z = 2'd2
    } pack_state_t;

endpackage

// File: rtl/fixed_round_clamp.sv
// Combinational round-half-up of a signed fixed-point value to an integer,
// then clamp to [0, MAX] with a flag when the clamp was applied.
module fixed_round_clamp #(
    parameter int IN_W      = 16,
    parameter int FRAC_BITS = 6,
    parameter int OUT_W     = 9,
    parameter int MAX       = 319
) (
    input  logic [IN_W-1:0]  d,
    output logic [OUT_W-1:0] value,
    output logic             clip
);

    localparam logic signed [IN_W:0] HALF_S = $signed((IN_W+1)'(1 << (FRAC_BITS-1)));
    localparam logic signed [IN_W:0] MAX_S  = $signed((IN_W+1)'(MAX));

    logic signed [IN_W:0] ext;
    logic signed [IN_W:0] rounded;

    always_comb begin
        // One guard bit so adding the half-LSB to the most positive input cannot wrap.
        ext     = $signed({d[IN_W-1], d});
        rounded = (ext + HALF_S) >>> FRAC_BITS;
        if (rounded < 0) begin
            value = '0;
            clip  = 1'b1;
        end else if (rounded > MAX_S) begin
            value = OUT_W'(MAX);
            clip  = 1'b1;
        end else begin
            value = rounded[OUT_W-1:0];
            clip  = 1'b0;
        end
    end

endmodule

// File: rtl/fixed_vertex_packer.sv
// Groups x, y, z fixed-point beats into one rounded/clamped vertex and presents it
// on a single-entry registered valid/ready output.
module fixed_vertex_packer
    import vertex_pkg::*;
(
    input  logic            clk,
    input  logic            rst_n,
    input  logic [IN_W-1:0] s_tdata,
    input  logic            s_tvalid,
    output logic            s_tready,
    output logic [X_W-1:0]  m_x,
    output logic [Y_W-1:0]  m_y,
    output logic [Z_W-1:0]  m_z,
    output logic            m_clip,
    output logic            m_valid,
    input  logic            m_ready
);

    logic [X_W-1:0] x_val;
    logic [Y_W-1:0] y_val;
    logic [Z_W-1:0] z_val;
    logic           x_clip, y_clip, z_clip;

    fixed_round_clamp #(.IN_W(IN_W), .FRAC_BITS(FRAC_BITS), .OUT_W(X_W), .MAX(H_RES-1))
        u_rc_x (.d(s_tdata), .value(x_val), .clip(x_clip));
    fixed_round_clamp #(.IN_W(IN_W), .FRAC_BITS(FRAC_BITS), .OUT_W(Y_W), .MAX(V_RES-1))
        u_rc_y (.d(s_tdata), .value(y_val), .clip(y_clip));
    fixed_round_clamp #(.IN_W(IN_W), .FRAC_BITS(FRAC_BITS), .OUT_W(Z_W), .MAX((1 << Z_W)-1))
        u_rc_z (.d(s_tdata), .value(z_val), .clip(z_clip));

    pack_state_t    state_q, state_d;
    logic [X_W-1:0] stage_x_q, stage_x_d;
    logic [Y_W-1:0] stage_y_q, stage_y_d;
    logic           clip_x_q, clip_x_d;
    logic           clip_y_q, clip_y_d;
    vertex_t        out_q, out_d;
    logic           m_valid_q, m_valid_d;
    logic           accept;

    // Only the z beat waits on the output register; x and y always land in staging.
    assign s_tready = (state_q != S_Z) || !m_valid_q || m_ready;
    assign accept   = s_tvalid && s_tready;

    always_comb begin
        // NOTE: every target gets its held value first, so no path through the case infers a latch.
        state_d   = state_q;
        stage_x_d = stage_x_q;
        stage_y_d = stage_y_q;
        clip_x_d  = clip_x_q;
        clip_y_d  = clip_y_q;
        out_d     = out_q;
        m_valid_d = m_valid_q && !m_ready;

        case (state_q)
            S_X: if (accept) begin
                stage_x_d = x_val;
                clip_x_d  = x_clip;
                state_d   = S_Y;
            end
            S_Y: if (accept) begin
                stage_y_d = y_val;
                clip_y_d  = y_clip;
                state_d   = S_Z;
            end
            S_Z: if (accept) begin
                out_d.x    = stage_x_q;
                out_d.y    = stage_y_q;
                out_d.z    = z_val;
                out_d.clip = clip_x_q | clip_y_q | z_clip;
                m_valid_d  = 1'b1;
                state_d    = S_X;
            end
            default: state_d = S_X;
        endcase
    end

    // NOTE: state updates use non-blocking assignment so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= S_X;
            stage_x_q <= '0;
            stage_y_q <= '0;
            clip_x_q  <= 1'b0;
            clip_y_q  <= 1'b0;
            out_q     <= '0;
            m_valid_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            stage_x_q <= stage_x_d;
            stage_y_q <= stage_y_d;
            clip_x_q  <= clip_x_d;
            clip_y_q  <= clip_y_d;
            out_q     <= out_d;
            m_valid_q <= m_valid_d;
        end
    end

    assign m_x     = out_q.x;
    assign m_y     = out_q.y;
    assign m_z     = out_q.z;
    assign m_clip  = out_q.clip;
    assign m_valid = m_valid_q;

endmodule
